// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stage indices,
// FSM encodings and the hold/bubble patterns driven onto the stage registers.
package pipe_ctrl_pkg;

  localparam int NSTG      = 5;
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

  // Memory wait freezes everything upstream of MEM/WB and bubbles MEM/WB.
  localparam logic [NSTG-1:0] STALL_ALL = 5'b11111;
  localparam logic [NSTG-1:0] STALL_MEM = 5'b01111;
  localparam logic [NSTG-1:0] FLUSH_MEM = 5'b10000;
  localparam logic [NSTG-1:0] STALL_LU  = 5'b00011;
  localparam logic [NSTG-1:0] FLUSH_LU  = 5'b00100;
  localparam logic [NSTG-1:0] FLUSH_BR  = 5'b00110;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  output logic       load_use_o
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_memread_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: data-memory wait FSM with timeout, load-use
// and branch resolution, priority mux onto the stage registers, stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_stall, load_use;

  hazard_detect u_hazard (
    .ex_memread_i  (ex_memread_i),
    .ex_rd_i       (ex_rd_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .load_use_o    (load_use)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        if (mem_req_i && !mem_ack_i) begin
          state_d   = ST_WAIT;
          mem_stall = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
          if (wcnt_q != WCNT_W'(MEM_TIMEOUT)) wcnt_d = wcnt_q + 1'b1;
          // The edge closing the last permitted wait cycle lands in ERR.
          if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) state_d = ST_ERR;
        end
      end
      ST_ERR:  ;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset forces the hold/bubble vectors low even though they are combinational.
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (rst_i) begin
      stall_o = '0;
    end else if (state_q == ST_ERR) begin
      stall_o = STALL_ALL;
    end else if (mem_stall) begin
      stall_o = STALL_MEM;
      flush_o = FLUSH_MEM;
    end else if (load_use) begin
      stall_o = STALL_LU;
      flush_o = FLUSH_LU;
    end else if (ex_branch_taken_i) begin
      flush_o = FLUSH_BR;
    end
  end

  assign mem_err_d   = mem_err_q || (state_d == ST_ERR);
  assign cnt_d       = cnt_q + CNT_W'(stall_o[STG_PC]);
  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed + randomized bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i, ex_memread_i, ex_branch_taken_i;
  logic        mem_req_i, mem_ack_i;
  logic [4:0]  stall_o, flush_o;
  logic        mem_err_o;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Model: 0 = no access outstanding, 1 = waiting on memory, 2 = timed out.
  int          m_mode;
  int          m_waits;
  bit          m_err;
  logic [31:0] m_cnt;
  logic [4:0]  e_stall, e_flush;
  logic [31:0] cnt_mark;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_rs1_used_i     (id_rs1_used_i),
    .id_rs2_used_i     (id_rs2_used_i),
    .ex_memread_i      (ex_memread_i),
    .ex_rd_i           (ex_rd_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .mem_req_i         (mem_req_i),
    .mem_ack_i         (mem_ack_i),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .mem_err_o         (mem_err_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_waits = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic set_in(input bit req, input bit ack, input bit mrd, input int rd,
                        input int rs1, input int rs2, input bit u1, input bit u2, input bit br);
    mem_req_i = req; mem_ack_i = ack; ex_memread_i = mrd; ex_rd_i = 5'(rd);
    id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2); id_rs1_used_i = u1; id_rs2_used_i = u2;
    ex_branch_taken_i = br;
  endtask

  task automatic expect_outputs();
    bit mem_wait, lu;
    mem_wait = (m_mode == 0 && mem_req_i && !mem_ack_i) || (m_mode == 1 && !mem_ack_i);
    lu = ex_memread_i && ex_rd_i != 0 &&
         ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
    e_stall = 5'b00000; e_flush = 5'b00000;
    if (m_mode == 2)        e_stall = 5'b11111;
    else if (mem_wait)      begin e_stall = 5'b01111; e_flush = 5'b10000; end
    else if (lu)            begin e_stall = 5'b00011; e_flush = 5'b00100; end
    else if (ex_branch_taken_i) e_flush = 5'b00110;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    #1;
    expect_outputs();
    chk("stall", 32'(stall_o), 32'(e_stall));
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("overlap", 32'(stall_o & flush_o), 32'd0);
    chk("mem_err", 32'(mem_err_o), 32'(m_err));
    chk("stall_cnt", stall_cnt_o, m_cnt);
    if (e_stall[0]) m_cnt = m_cnt + 1;
    case (m_mode)
      0: if (mem_req_i && !mem_ack_i) begin m_mode = 1; m_waits = 0; end
      1: if (mem_ack_i) m_mode = 0;
         else begin
           m_waits++;
           if (m_waits >= TO) begin m_mode = 2; m_err = 1; end
         end
      default: ;
    endcase
    @(negedge clk);
  endtask

  // Assert reset between edges and check the forced-zero outputs right away.
  task automatic async_reset();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_err", 32'(mem_err_o), 32'd0);
    chk("rst_cnt", stall_cnt_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    rst_i = 1'b1;
    model_reset();
    set_in(1, 0, 1, 5, 5, 0, 1, 0, 1);
    @(negedge clk);
    #1;
    chk("por_stall", 32'(stall_o), 32'd0);
    chk("por_flush", 32'(flush_o), 32'd0);
    chk("por_cnt", stall_cnt_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Load-use on rs1, then the same with x0, then rs2 gated by its used bit.
    set_in(0, 0, 1, 5, 5, 0, 1, 0, 0);
    #1 chk("lu_stall_const", 32'(stall_o), 32'b00011);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 1, 0, 0, 0, 1, 1, 0); step();
    set_in(0, 0, 1, 7, 1, 7, 1, 0, 0); step();
    set_in(0, 0, 1, 7, 1, 7, 1, 1, 0); step();

    // Zero-wait access.
    cnt_mark = m_cnt;
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0); step();
    chk("zw_cnt_const", stall_cnt_o, cnt_mark);

    // Three wait cycles, ack on the fourth.
    cnt_mark = stall_cnt_o;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("ack_stall_const", 32'(stall_o), 32'd0);
    step();
    chk("w3_cnt_const", stall_cnt_o - cnt_mark, 32'd3);

    // Branch during a memory wait is suppressed until the access completes.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("br_wait_flush_const", 32'(flush_o), 32'b10000);
    step(); step();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 1); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("br_after_flush_const", 32'(flush_o), 32'b00110);
    step();

    // Timeout: one idle request cycle, TO wait cycles, then held in error.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO + 1; i++) step();
    chk("to_err_const", 32'(mem_err_o), 32'd1);
    set_in(1, 1, 1, 3, 3, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step();
    chk("err_stall_const", 32'(stall_o), 32'b11111);
    async_reset();

    // Reset mid-wait abandons the access.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    async_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Randomized traffic with periodic resets to escape the error state.
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 59) begin
        async_reset();
      end else begin
        set_in($urandom_range(0, 1), ($urandom_range(0, 9) < 4), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 5-stage core. It drives a per-register hold and bubble-insert vector to PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and resolves three hazard sources: data-memory wait, load-use and taken branch. It owns a small FSM that sequences the multi-cycle data-memory handshake, with a timeout. It also keeps a stall-cycle performance counter.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive wait cycles on one data-memory access before the error state.
- CNT_W, 32: width of the stall performance counter.
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- id_rs1_i, id_rs2_i  in  5 each  source register addresses of the instruction in ID.
- id_rs1_used_i, id_rs2_used_i  in  1 each  the ID instruction reads rs1 / rs2.
- ex_memread_i  in  1  the instruction in EX is a load.
- ex_rd_i  in  5  destination register of the instruction in EX.
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump.
- mem_req_i  in  1  the MEM-stage instruction accesses data memory (load or store).
- mem_ack_i  in  1  data memory completes the access this cycle.
- stall_o  out  5  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
- flush_o  out  5  bubble-insert enables, same bit order. Flush loads the register's reset contents.
- mem_err_o  out  1  sticky flag for a data-memory timeout.
- stall_cnt_o  out  CNT_W  number of cycles with stall_o[0] high.

## Operation
- FSM states and transitions:
  - IDLE → WAIT when mem_req_i=1 and mem_ack_i=0.
  - WAIT → IDLE when mem_ack_i=1.
  - WAIT → ERR when the wait counter reaches MEM_TIMEOUT with no ack.
  - ERR is exited only by reset.
- Memory stall:
  - Condition: (IDLE and mem_req_i and !mem_ack_i) or WAIT-without-ack.
  - Response: stall_o=5'b01111 and flush_o=5'b10000, so a bubble enters MEM/WB.
  - An ack in IDLE on the same cycle as the request causes no stall.
  - In the WAIT ack cycle: stall_o=0 and the pipeline advances.
- ERR state: stall_o=5'b11111, flush_o=0, mem_err_o=1.
- Load-use hazard:
  - Condition: ex_memread_i=1, ex_rd_i≠0, and ex_rd_i matches a used ID source.
  - Response: stall_o=5'b00011, flush_o=5'b00100.
- Taken branch: flush_o=5'b00110, i.e. kill IF/ID and ID/EX. The PC redirect is handled outside this block.
- Priority: ERR > memory stall > load-use > branch.
  - A branch or load-use that coincides with a memory stall is suppressed.
  - EX is held during the memory stall, so the branch or hazard is re-evaluated when it releases.
- Invariant: flush_o[k] and stall_o[k] are never both 1.
- Wait counter:
  - Cleared in IDLE; increments each WAIT cycle.
  - Saturating; width is ceil(log2(MEM_TIMEOUT+1)).
- stall_cnt_o: increments on every cycle with stall_o[0]=1 and wraps modulo 2^CNT_W.

## Timing
- stall_o and flush_o are combinational from state and inputs, valid within the same cycle. The pipeline registers sample them at the next posedge.
- State, the wait counter, mem_err_o and stall_cnt_o update on posedge clk_i.
- While rst_i=1 (asynchronous):
  - State=IDLE.
  - Wait counter=0, stall_cnt_o=0, mem_err_o=0.
  - stall_o=0 and flush_o=0, forced regardless of inputs.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately and the access is abandoned.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and the hazard input is gone.
- Timeout: ERR is entered at the posedge after MEM_TIMEOUT consecutive WAIT cycles without ack. mem_err_o rises on that same edge.

## Structure
- Shared package/define file holds:
  - Stage index constants: STG_PC=0, STG_IFID=1, STG_IDEX=2, STG_EXMEM=3, STG_MEMWB=4.
  - State encodings: IDLE=2'b00, WAIT=2'b01, ERR=2'b10.
  - The zero register address constant.
- One sub-module is natural: hazard_detect, the combinational load-use comparator. The FSM, priority mux and counters stay in pipe_ctrl.

## Test plan
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs1_i=5, id_rs1_used_i=1 → stall_o=00011 and flush_o=00100 for 1 cycle. Repeat with ex_rd_i=0 → no stall.
- Zero-wait memory: mem_req_i=1 with mem_ack_i=1 on the same cycle → stall_o=0, state stays IDLE, stall_cnt_o unchanged.
- 3-cycle wait: mem_req_i held, ack on the 4th cycle → stall_o=01111 and flush_o=10000 for 3 cycles, then 0 on the ack cycle; stall_cnt_o=3.
- Branch during memory wait: ex_branch_taken_i=1 while in WAIT → flush_o=10000 only. After the ack cycle, with the branch still asserted → flush_o=00110.
- Timeout with MEM_TIMEOUT=4: no ack → ERR after 4 WAIT cycles, mem_err_o=1, stall_o=11111, held until reset.
- Reset mid-WAIT: assert rst_i asynchronously between edges → all outputs 0 immediately; after release, state is IDLE.
